// File: rtl/hdx_pkg.sv
// Shared types and constants for the half-duplex responder.
// Define HDX_PARITY_EN to append an even-parity beat to every frame.
package hdx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_TURN_A,
        ST_WAIT_TX,
        ST_TX,
        ST_TURN_B
    } state_e;

    localparam int unsigned DATA_BEATS = 4;
`ifdef HDX_PARITY_EN
    localparam int unsigned BEATS = 5;
`else
    localparam int unsigned BEATS = 4;
`endif
    localparam int unsigned TURN_CYCLES_DEFAULT = 1;
    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/hdx_pad.sv
// Two-bit tristate pad: drives io when oe is high, always returns the resolved bus.
module hdx_pad (
    input  logic       oe,
    input  logic [1:0] dout,
    output logic [1:0] din,
    inout  wire  [1:0] io
);

    assign io  = oe ? dout : 2'bzz;
    assign din = io;

endmodule

// File: rtl/hdx_responder.sv
// Half-duplex 2-bit bus responder: receives a request byte, then returns one response byte.
// Build option: HDX_PARITY_EN adds a 5th even-parity beat in both directions.
module hdx_responder
    import hdx_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = TURN_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_stb,
    inout  wire  [1:0] bus_io,
    output logic       bus_oe,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_TURN  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DATA_LIMIT = CNT_W'(DATA_BEATS);

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       rx_shift, tx_byte;
    logic [7:0]       rx_shift_c;
    logic [1:0]       din, dout_c;
    logic             shift_c, done_c, fail_c, load_c;

    hdx_pad u_pad (
        .oe   (bus_oe),
        .dout (dout_c),
        .din  (din),
        .io   (bus_io)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_c = 1'b0;
        done_c  = 1'b0;
        fail_c  = 1'b0;
        load_c  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus_stb) begin
                    shift_c = 1'b1;
                    cnt_n   = CNT_W'(1);
                    state_n = ST_RX;
                end
            end
            ST_RX: begin
                if (bus_stb) begin
                    shift_c = (cnt < DATA_LIMIT);
                    if (cnt == LAST_BEAT) begin
                        cnt_n = '0;
`ifdef HDX_PARITY_EN
                        // Final beat carries even parity of the byte already shifted in.
                        if (din[0] != ^rx_shift) begin
                            fail_c  = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            done_c  = 1'b1;
                            state_n = ST_TURN_A;
                        end
`else
                        done_c  = 1'b1;
                        state_n = ST_TURN_A;
`endif
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    fail_c  = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end
            end
            ST_TURN_A: begin
                if (cnt == LAST_TURN) begin
                    cnt_n   = '0;
                    state_n = ST_WAIT_TX;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_WAIT_TX: begin
                // A new request pre-empts a pending response offer.
                if (bus_stb) begin
                    shift_c = 1'b1;
                    cnt_n   = CNT_W'(1);
                    state_n = ST_RX;
                end else if (tx_valid && tx_ready) begin
                    load_c  = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_TX;
                end
            end
            ST_TX: begin
                if (cnt == LAST_BEAT) begin
                    cnt_n   = '0;
                    state_n = ST_TURN_B;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_TURN_B: begin
                if (cnt == LAST_TURN) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Beats arrive LSB first, so shift in from the top.
    assign rx_shift_c = shift_c ? {din, rx_shift[7:2]} : rx_shift;

    always_comb begin
        dout_c = {1'b0, ^tx_byte};
        case (cnt)
            CNT_W'(0): dout_c = tx_byte[1:0];
            CNT_W'(1): dout_c = tx_byte[3:2];
            CNT_W'(2): dout_c = tx_byte[5:4];
            CNT_W'(3): dout_c = tx_byte[7:6];
            default:   dout_c = {1'b0, ^tx_byte};
        endcase
    end

    // Status flags follow the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_oe   <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_data  <= 8'h00;
            rx_shift <= 8'h00;
            tx_byte  <= 8'h00;
        end else begin
            bus_oe   <= (state_n == ST_TX);
            tx_ready <= (state_n == ST_WAIT_TX);
            busy     <= (state_n != ST_IDLE);
            rx_valid <= done_c;
            rx_err   <= fail_c;
            rx_shift <= rx_shift_c;
            if (done_c) rx_data <= rx_shift_c;
            if (load_c) tx_byte <= tx_data;
        end
    end

endmodule

// File: doc/hdx_responder.md
HDX_RESPONDER -- requirements
Module: hdx_responder

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 1, bus-idle cycles between request and response and after response (range 1..4).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port bus_stb  input  1  initiator strobe, high for each request beat.
REQ-005 SHALL have port bus_io  inout  2  shared half-duplex data bus, one 2-bit beat per cycle, LSB beat first.
REQ-006 SHALL have port bus_oe  output  1  high while bus_io is driven by this block.
REQ-007 SHALL have port rx_valid  output  1  one-cycle pulse, request byte available.
REQ-008 SHALL have port rx_data  output  8  received request byte, held until the next rx_valid.
REQ-009 SHALL have port rx_err  output  1  one-cycle pulse, malformed request.
REQ-010 SHALL have port tx_valid / tx_data  input  1 / 8  response byte offer.
REQ-011 SHALL have port tx_ready  output  1  high in WAIT_TX only.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, RX, TURN_A, WAIT_TX, TX, TURN_B.
REQ-014 IDLE: bus_stb=1 SHALL sample bus_io as beat 0 into rx_data[1:0] and move to RX.
REQ-015 RX: each cycle with bus_stb=1 SHALL sample the next beat; after the final beat (4th, or 5th when parity is enabled), rx_valid SHALL pulse the next cycle and the state SHALL move to TURN_A.
REQ-016 RX: bus_stb=0 before the final beat SHALL pulse rx_err, discard partial data (rx_data unchanged), and return to IDLE.
REQ-017 TURN_A / TURN_B SHALL last exactly TURN_CYCLES cycles with bus_oe=0 and bus_io=2'bzz.
REQ-018 WAIT_TX: tx_valid&tx_ready SHALL capture tx_data and enter TX; wait time is unbounded.
REQ-019 WAIT_TX: bus_stb=1 SHALL abandon the response, drop tx_ready, and sample beat 0 exactly as in IDLE (new request); if tx_valid is high in the same cycle, bus_stb wins.
REQ-020 TX: bus_oe=1, driving tx_data[1:0], [3:2], [5:4], [7:6] on consecutive cycles, then TURN_B, then IDLE.
REQ-021 bus_stb during TX/TURN_A/TURN_B SHALL be ignored.
REQ-022 bus_io SHALL equal 2'bzz whenever bus_oe=0; bus_oe SHALL be registered.

Reset
REQ-023 rst SHALL force IDLE; bus_oe, rx_valid, rx_err, tx_ready, busy=0; rx_data=8'h00.
REQ-024 rst asserted mid-TX SHALL release bus_io (bus_oe=0) from the cycle after the reset edge; no partial response resumes.

Configuration
REQ-025 Macro HDX_PARITY_EN defined: a 5th beat is appended in both directions, bit[0] = even parity of the byte and bit[1] = 0; an RX parity mismatch pulses rx_err instead of rx_valid and returns to IDLE without a response.
REQ-026 HDX_PARITY_EN undefined: frames are 4 beats and rx_err is raised only by short frames.

Structure
REQ-027 Package hdx_pkg SHALL hold the state enum, the BEATS constant (4 or 5 per macro), and the TURN_CYCLES default.
REQ-028 Sub-module hdx_pad SHALL contain the tristate (oe, dout[1:0], din[1:0], io[1:0]); hdx_responder SHALL contain no other Z assignments.

Verification
REQ-029 Request beats 2'b01, 2'b10, 2'b11, 2'b00 with bus_stb held 4 cycles -> rx_valid pulse, rx_data=8'h39, then 1 cycle of Z.
REQ-030 After REQ-029, tx_valid with tx_data=8'hA5 -> bus_io drives 01, 01, 10, 10 with bus_oe=1 for 4 cycles, then Z for TURN_CYCLES, busy=0.
REQ-031 bus_stb dropped after 2 beats -> rx_err pulse, no rx_valid, rx_data unchanged, IDLE.
REQ-032 rst asserted on the 2nd TX beat -> bus_oe=0 the next cycle, all outputs at reset values, a fresh request accepted normally.
REQ-033 bus_stb and tx_valid asserted together in WAIT_TX -> no TX, new RX frame received correctly.
REQ-034 HDX_PARITY_EN defined, 8'h39 request with parity bit 1 -> rx_err, no response; with parity bit 0 -> rx_valid and a 5-beat response.
